word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/serial_pkg.sv | 12 +
 rtl/word_serializer.sv | 84 ++++++++
 tb/tb_word_serializer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial word path.
// Used by the serializer and by the downstream remainder checker.
package serial_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/word_serializer.sv
// MSB-first parallel-to-serial converter with valid/ready on both sides.
// Chains words with no bubble when a load meets the last-bit transfer.
module word_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_first,
    output logic             ser_last,
    output logic [7:0]       word_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    ser_state_t       r_state;
    ser_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [7:0]       r_word_cnt;
    logic [7:0]       w_word_cnt_nxt;

    logic w_xfer;
    logic w_last_xfer;
    logic w_load;

    assign ser_valid   = (r_state == SHIFT);
    assign ser_out     = ser_valid & r_shift[WIDTH-1];
    assign ser_first   = ser_valid & (r_cnt == CNT_MAX);
    assign ser_last    = ser_valid & (r_cnt == '0);
    assign w_xfer      = ser_valid & ser_ready;
    assign w_last_xfer = w_xfer & ser_last;
    assign load_ready  = (r_state == IDLE) | w_last_xfer;
    assign w_load      = load_valid & load_ready;
    assign word_cnt    = r_word_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_word_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_word_cnt <= w_word_cnt_nxt;
        end
    end

    // A load takes priority so a new word can follow the last bit directly.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_word_cnt_nxt = r_word_cnt;
        if (w_last_xfer) begin
            w_word_cnt_nxt = r_word_cnt + 8'd1;
        end
        if (w_load) begin
            w_state_nxt = SHIFT;
            w_shift_nxt = load_data;
            w_cnt_nxt   = CNT_MAX;
        end else if (w_last_xfer) begin
            w_state_nxt = IDLE;
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
        end else if (w_xfer) begin
            w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
            w_cnt_nxt   = r_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Directed self-checking bench for word_serializer (WIDTH=8).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_word_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] load_data;
    logic       load_valid;
    logic       load_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_first;
    logic       ser_last;
    logic [7:0] word_cnt;

    int checks = 0;
    int errors = 0;

    word_serializer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_data (load_data),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(ser_valid), 32'd0);
        chk({tag, "_out"},   32'(ser_out),   32'd0);
        chk({tag, "_first"}, 32'(ser_first), 32'd0);
        chk({tag, "_last"},  32'(ser_last),  32'd0);
        chk({tag, "_ready"}, 32'(load_ready), 32'd1);
    endtask

    task automatic chk_bit(input string tag, input logic b,
                           input logic f, input logic l);
        chk({tag, "_valid"}, 32'(ser_valid), 32'd1);
        chk({tag, "_out"},   32'(ser_out),   32'(b));
        chk({tag, "_first"}, 32'(ser_first), 32'(f));
        chk({tag, "_last"},  32'(ser_last),  32'(l));
    endtask

    task automatic send_zero();
        load_valid = 1'b1;
        load_data  = 8'h00;
        step();
        load_valid = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        logic [7:0] w;
        int         rem;
        int         k;

        rst        = 1'b0;
        load_data  = 8'h00;
        load_valid = 1'b0;
        ser_ready  = 1'b1;

        // Reset state
        #2;
        chk_idle("rst");
        chk("rst_wcnt", 32'(word_cnt), 32'd0);
        step();
        rst = 1'b1;
        step();
        chk_idle("post_rst");

        // 8'h0C, continuous ready
        load_data  = 8'h0C;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        load_data  = 8'hFF;
        w   = 8'h0C;
        rem = 0;
        for (int i = 0; i < 8; i++) begin
            chk_bit("w0C", w[7-i], i == 0, i == 7);
            chk("w0C_lr", 32'(load_ready), 32'(i == 7));
            rem = (rem * 2 + int'(ser_out)) % 3;
            step();
        end
        chk_idle("w0C_end");
        chk("w0C_wcnt", 32'(word_cnt), 32'd1);
        chk("w0C_rem3", 32'(rem), 32'd0);

        // 8'hFF then 8'h01 held on load_valid
        load_data  = 8'hFF;
        load_valid = 1'b1;
        step();
        load_data = 8'h01;
        w = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            chk_bit("bbFF", w[7-i], i == 0, i == 7);
            chk("bbFF_lr", 32'(load_ready), 32'(i == 7));
            step();
        end
        load_valid = 1'b0;
        w = 8'h01;
        for (int i = 0; i < 8; i++) begin
            chk_bit("bb01", w[7-i], i == 0, i == 7);
            step();
        end
        chk_idle("bb_end");
        chk("bb_wcnt", 32'(word_cnt), 32'd3);

        // 8'hA5 with stall on cycles 3-5
        load_data  = 8'hA5;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        w = 8'hA5;
        k = 0;
        for (int c = 1; c <= 11; c++) begin
            ser_ready = !(c >= 3 && c <= 5);
            chk_bit("stall", w[7-k], k == 0, k == 7);
            step();
            if (ser_ready) k++;
        end
        ser_ready = 1'b1;
        chk_idle("stall_end");
        chk("stall_wcnt", 32'(word_cnt), 32'd4);

        // 8'h81 aborted by reset after 3 bits
        load_data  = 8'h81;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (3) step();
        chk_bit("abort_pre", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk_idle("abort");
        chk("abort_wcnt", 32'(word_cnt), 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        chk_idle("abort_rel");
        chk("abort_wcnt2", 32'(word_cnt), 32'd0);
        load_data  = 8'h03;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        w = 8'h03;
        for (int i = 0; i < 8; i++) begin
            chk_bit("w03", w[7-i], i == 0, i == 7);
            step();
        end
        chk_idle("w03_end");
        chk("w03_wcnt", 32'(word_cnt), 32'd1);

        // Wrap of word_cnt and refusal of mid-word loads
        repeat (254) send_zero();
        chk("wrap_255", 32'(word_cnt), 32'd255);
        load_data  = 8'h00;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (3) step();
        load_data  = 8'hFF;
        load_valid = 1'b1;
        chk("mid_lr", 32'(load_ready), 32'd0);
        step();
        chk("mid_lr2", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        chk_bit("mid_hold", 1'b0, 1'b0, 1'b0);
        repeat (4) step();
        chk_idle("wrap_end");
        chk("wrap_0", 32'(word_cnt), 32'd0);
        step();
        chk_idle("wrap_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
